// File: rtl/eth_tx_sequencer_if.sv
// Handshake and data bundle between the frame sequencer, the source arbiter,
// the CRC block and the GMII side.
interface eth_tx_sequencer_if;
    logic        start;
    logic        stop;
    logic        busy;
    logic        src_rd;
    logic [7:0]  src_data;
    logic        src_last;
    logic        crc_init;
    logic        crc_calc;
    logic        crc_shift;
    logic [7:0]  crc_byte;
    logic        tx_en;
    logic        tx_er;
    logic [7:0]  tx_data;
    logic [15:0] frm_cnt;
    logic [7:0]  err_cnt;

    // Environment side: arbiter, byte source, CRC block, GMII sink.
    modport master (
        output start, src_data, src_last, crc_byte,
        input  stop, busy, src_rd, crc_init, crc_calc, crc_shift,
               tx_en, tx_er, tx_data, frm_cnt, err_cnt
    );

    // Sequencer side.
    modport slave (
        input  start, src_data, src_last, crc_byte,
        output stop, busy, src_rd, crc_init, crc_calc, crc_shift,
               tx_en, tx_er, tx_data, frm_cnt, err_cnt
    );
endinterface

// File: rtl/eth_tx_sequencer.sv
// Ethernet TX frame sequencer: preamble/SFD, payload streaming, zero pad,
// FCS insertion, inter-frame gap, and good/truncated frame counters.
module eth_tx_sequencer #(
    parameter int IFG_BYTES = 12,
    parameter int MIN_LEN   = 60,
    parameter int MAX_LEN   = 1514
) (
    input  logic                  clk,
    input  logic                  rst_n,
    eth_tx_sequencer_if.slave     bus
);
    localparam int CW = $clog2(IFG_BYTES + 8);
    localparam logic [CW-1:0] PRE_END = CW'(6);
    localparam logic [CW-1:0] FCS_END = CW'(3);
    localparam logic [CW-1:0] IFG_END = CW'(IFG_BYTES - 1);
    localparam logic [10:0]   MIN_B   = 11'(MIN_LEN);
    localparam logic [10:0]   MAX_B   = 11'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_ERR, S_IFG, S_DONE
    } state_t;

    state_t       state, state_nxt;
    logic [CW-1:0] ph_cnt;
    logic [10:0]  byte_cnt;
    logic [7:0]   data_q;
    logic         last_q;
    logic         bad_q;
    logic [15:0]  frm_q;
    logic [7:0]   err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_PRE;
            S_PRE:  if (ph_cnt == PRE_END) state_nxt = S_SFD;
            S_SFD:  state_nxt = S_DATA;
            S_DATA: begin
                // last_q tags the byte on tx_data now; a clean last at MAX wins over truncation
                if (last_q)                state_nxt = (byte_cnt < MIN_B) ? S_PAD : S_FCS;
                else if (byte_cnt == MAX_B) state_nxt = S_ERR;
            end
            S_PAD:  if (byte_cnt == MIN_B) state_nxt = S_FCS;
            S_FCS:  if (ph_cnt == FCS_END) state_nxt = S_IFG;
            S_ERR:  state_nxt = S_IFG;
            S_IFG:  if (ph_cnt == IFG_END) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.tx_en     = 1'b0;
        bus.tx_er     = 1'b0;
        bus.tx_data   = 8'h00;
        bus.src_rd    = 1'b0;
        bus.crc_init  = 1'b0;
        bus.crc_calc  = 1'b0;
        bus.crc_shift = 1'b0;
        case (state)
            S_PRE: begin
                bus.tx_en   = 1'b1;
                bus.tx_data = 8'h55;
                bus.src_rd  = (ph_cnt == PRE_END);
            end
            S_SFD: begin
                bus.tx_en    = 1'b1;
                bus.tx_data  = 8'hD5;
                bus.crc_init = 1'b1;
                bus.src_rd   = 1'b1;
            end
            S_DATA: begin
                bus.tx_en    = 1'b1;
                bus.tx_data  = data_q;
                bus.crc_calc = 1'b1;
                // reads run two cycles ahead, so the one extra read lands while byte N-1 is shown
                bus.src_rd   = !last_q && (byte_cnt != MAX_B);
            end
            S_PAD: begin
                bus.tx_en    = 1'b1;
                bus.crc_calc = 1'b1;
            end
            S_FCS: begin
                bus.tx_en     = 1'b1;
                bus.tx_data   = bus.crc_byte;
                bus.crc_shift = 1'b1;
            end
            S_ERR: begin
                bus.tx_en = 1'b1;
                bus.tx_er = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.stop    = (state == S_DONE);
    assign bus.frm_cnt = frm_q;
    assign bus.err_cnt = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_cnt   <= '0;
            byte_cnt <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            bad_q    <= 1'b0;
            frm_q    <= '0;
            err_q    <= '0;
        end else begin
            data_q <= bus.src_data;
            last_q <= bus.src_last;
            ph_cnt <= (state_nxt != state) ? '0 : ph_cnt + 1'b1;
            if (state == S_SFD)
                byte_cnt <= 11'd1;
            else if (state == S_DATA || state == S_PAD)
                byte_cnt <= byte_cnt + 11'd1;
            if (state == S_IDLE)     bad_q <= 1'b0;
            else if (state == S_ERR) bad_q <= 1'b1;
            if (state == S_ERR && err_q != 8'hFF) err_q <= err_q + 8'd1;
            if (state == S_DONE && !bad_q)        frm_q <= frm_q + 16'd1;
        end
    end
endmodule

// File: doc/eth_tx_sequencer.md
# eth_tx_sequencer

Transmit-side frame sequencer between the source arbiter and the GMII byte interface. On a `start` pulse it emits preamble and SFD, streams payload bytes from the currently selected source, zero-pads short frames, inserts the 4-byte FCS from the external CRC block, and enforces the inter-frame gap. It then returns a one-cycle `stop` pulse, which releases the arbiter for the next grant.

## Interface
- `IFG_BYTES`, 12: idle cycles after the last FCS byte, before `stop`.
- `MIN_LEN`, 60: minimum frame length before FCS (DA+SA+type+payload); shorter frames are padded with 0x00.
- `MAX_LEN`, 1514: maximum frame length before FCS; longer frames are truncated and flagged.

- `clk` in 1: clock, 125 MHz byte clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse from the arbiter requesting a frame.
- `stop` out 1: one-cycle pulse when frame and IFG are complete.
- `busy` out 1: high from the cycle after an accepted `start` through the `stop` cycle.
- `src_rd` out 1: read strobe to the selected source.
- `src_data` in 8: source byte, valid the cycle after `src_rd`.
- `src_last` in 1: qualifies `src_data` as the final frame byte.
- `crc_init` out 1: clears the CRC accumulator.
- `crc_calc` out 1: the CRC block absorbs `tx_data` this cycle.
- `crc_shift` out 1: the CRC block advances to its next FCS byte at the end of this cycle.
- `crc_byte` in 8: current FCS byte from the CRC block.
- `tx_en` out 1: GMII transmit enable.
- `tx_er` out 1: GMII transmit error.
- `tx_data` out 8: GMII transmit data.
- `frm_cnt` out 16: count of completed good frames; wraps 0xFFFF→0.
- `err_cnt` out 8: count of truncated frames; saturates at 0xFF.

## Operation
- States: IDLE → PRE → SFD → DATA → [PAD] → FCS → IFG → DONE → IDLE.
  - Error path: DATA → IFG on overlength.
- IDLE: `start` high moves to PRE. `start` in any other state is ignored, with no queuing.
- PRE: 7 cycles, `tx_data`=0x55, `tx_en`=1.
  - `src_rd`=1 in the 7th PRE cycle.
- SFD: 1 cycle, `tx_data`=0xD5, `crc_init`=1, `src_rd`=1.
- DATA: `tx_data` is the registered `src_data`; `crc_calc`=1; `src_rd`=1 each cycle.
  - A 11-bit `byte_cnt` counts bytes shown, starting at 1.
  - The byte tagged `src_last` is the final DATA byte.
  - Exactly one extra `src_rd` follows the last byte; sources ignore reads after last.
- After the last byte: if `byte_cnt` < `MIN_LEN`, go to PAD; otherwise go to FCS.
- PAD: `tx_data`=0x00, `crc_calc`=1, until `byte_cnt`=`MIN_LEN`.
- FCS: 4 cycles, `tx_data`=`crc_byte` (combinational mux), `crc_shift`=1, `crc_calc`=0.
- IFG: `IFG_BYTES` cycles, `tx_en`=0, `tx_data`=0x00.
- DONE: `stop`=1 for one cycle.
  - On a good frame, `frm_cnt` increments in this cycle.
- Overlength: if `byte_cnt` reaches `MAX_LEN` and that byte lacks `src_last`:
  - next cycle `tx_en`=1, `tx_er`=1, `tx_data`=0x00 for one cycle, then IFG;
  - `src_rd` drops; `err_cnt` increments;
  - `stop` is still issued after IFG.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-frame: outputs clear asynchronously. The arbiter is reset by the same `rst_n`.
- `start` sampled high in cycle 0 (frame of N bytes, N ≥ `MIN_LEN`):
  - PRE occupies cycles 1–7; SFD is cycle 8;
  - DATA/PAD occupy cycles 9..8+max(N,`MIN_LEN`);
  - FCS occupies the next 4 cycles.
- `tx_en` is high for 12+max(N,`MIN_LEN`) cycles. IFG follows; `stop` arrives at cycle 13+max(N,`MIN_LEN`)+`IFG_BYTES`.
- Minimum `start`→`stop` spacing is 85 cycles, with defaults and a 60-byte frame.
- Next `start` is accepted at the earliest in the cycle after `stop`.
- `src_last` on a byte with `byte_cnt`=`MIN_LEN` exactly: no PAD, go to FCS.
- `src_last` on byte `MAX_LEN`: normal frame, no error.
- `frm_cnt` wrap and `err_cnt` saturation have no side effects.

## Test plan
- 64-byte frame, bytes 0x00..0x3F:
  - preamble 7×0x55, 0xD5, then 64 data bytes, then 4 FCS bytes;
  - `tx_en` high for 76 cycles;
  - `stop` at cycle 89; `frm_cnt`=1.
- 10-byte frame:
  - 50 bytes of 0x00 pad after data;
  - `crc_calc` high for 60 cycles;
  - `stop` at cycle 85.
- 1515-byte source with no `src_last` by byte 1514:
  - `tx_er` pulses at cycle 1523; `err_cnt`=1; `frm_cnt` unchanged;
  - `stop` pulses once, at cycle 1536.
- `start` re-pulsed at cycles 20 and 85 of an active 60-byte frame:
  - both ignored;
  - a single `stop` at cycle 85;
  - `start` at cycle 86 begins a new preamble at cycle 87.
- `rst_n` asserted during cycle 30 of DATA:
  - `tx_en`, `src_rd` and `busy` drop immediately;
  - after release, a new `start` transmits a clean frame.
- 65,536 back-to-back 60-byte frames: `frm_cnt` wraps to 0.
